// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one 4x4 sequential shift-add multiplier core
// among NREQ requesters. One operation is in flight at a time: grant, hold the
// operands, pulse START, wait for READY (or time out), then return the product.
module mult_share_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MIN_WAIT = 2,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                blif_clk_net,
  input  logic                blif_reset_net,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [4*NREQ-1:0]   req_a,
  input  logic [4*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [7:0]          rsp_p,
  output logic                rsp_err,
  output logic                mul_start,
  output logic [3:0]          mul_a,
  output logic [3:0]          mul_b,
  input  logic                mul_ready,
  input  logic [7:0]          mul_p,
  output logic                busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] grant_q, grant_d;
  logic [PtrW-1:0] pick_idx;
  logic            pick_found;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      p_q, p_d;
  logic            err_q, err_d;

  // Round-robin pick: first valid requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_found && req_valid[PtrW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = PtrW'(idx);
      end
    end
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick_idx;
          a_d     = req_a[4*pick_idx +: 4];
          b_d     = req_b[4*pick_idx +: 4];
          state_d = StLoad;
        end
      end
      StLoad: state_d = StStart;
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 4'd1;
        // READY seen too soon after START may be left over from the previous op.
        if (mul_ready && (32'(cnt_q) >= MIN_WAIT)) begin
          p_d     = mul_p;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (32'(cnt_q) >= TIMEOUT - 1) begin
          p_d     = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready[grant_q]) begin
          ptr_d   = (32'(grant_q) == NREQ - 1) ? '0 : grant_q + PtrW'(1);
          p_d     = '0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; the accept pulse is masked while reset is held.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    busy      = (state_q != StIdle);
    case (state_q)
      StIdle:  if (pick_found && !blif_reset_net) req_ready[pick_idx] = 1'b1;
      StStart: mul_start = 1'b1;
      StResp:  rsp_valid[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign mul_a   = a_q;
  assign mul_b   = b_q;
  assign rsp_p   = p_q;
  assign rsp_err = err_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a behavioural multiplier core whose
// READY timing is selectable: nominal (6 cycles after START), stuck high, never.
module tb_mult_share_sched;

  logic        blif_clk_net = 1'b0;
  logic        blif_reset_net;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [7:0]  rsp_p;
  logic        rsp_err;
  logic        mul_start;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic        mul_ready;
  logic [7:0]  mul_p;
  logic        busy;

  int          n_pass = 0;
  int          n_total = 0;
  int          mode = 0;
  int unsigned since_start = 0;

  mult_share_sched #(
    .NREQ    (4),
    .MIN_WAIT(2),
    .TIMEOUT (15)
  ) dut (
    .blif_clk_net  (blif_clk_net),
    .blif_reset_net(blif_reset_net),
    .req_valid     (req_valid),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_p         (rsp_p),
    .rsp_err       (rsp_err),
    .mul_start     (mul_start),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_ready     (mul_ready),
    .mul_p         (mul_p),
    .busy          (busy)
  );

  always #5 blif_clk_net = ~blif_clk_net;

  // Core model: cycles since the last START pulse.
  always @(posedge blif_clk_net) begin
    if (mul_start) since_start <= 1;
    else if (since_start != 0 && since_start < 100) since_start <= since_start + 1;
  end

  assign mul_ready = (mode == 1) ? 1'b1 : (mode == 0) ? (since_start == 6) : 1'b0;
  assign mul_p     = mul_ready ? ({4'b0000, mul_a} * {4'b0000, mul_b}) : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
  endtask

  task automatic do_reset(input string tag);
    blif_reset_net = 1'b1;
    @(negedge blif_clk_net);
    @(negedge blif_clk_net);
    check({tag, " outputs zero"},
          32'({req_ready, rsp_valid, rsp_p, rsp_err, mul_start, mul_a, mul_b, busy}), 32'(0));
    blif_reset_net = 1'b0;
  endtask

  // One full operation for requester g; hold > 0 withholds rsp_ready that many cycles.
  task automatic run_op(input int g, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] p, input logic err, input int lat,
                        input logic keep, input int hold, input string tag);
    logic [3:0] oh;
    int         n;
    logic       stable_ok, no_start, no_grant;
    oh = 4'b0001 << g;
    #1;
    n = 0;
    while (req_ready == 4'b0000 && n < 20) begin
      @(negedge blif_clk_net);
      n++;
    end
    check({tag, " grant"}, 32'(req_ready), 32'(oh));
    @(negedge blif_clk_net);
    check({tag, " mul_a"}, 32'(mul_a), 32'(a));
    check({tag, " mul_b"}, 32'(mul_b), 32'(b));
    check({tag, " busy"}, 32'(busy), 32'(1));
    if (!keep) req_valid[g] = 1'b0;
    @(negedge blif_clk_net);
    check({tag, " start"}, 32'(mul_start), 32'(1));
    @(negedge blif_clk_net);
    check({tag, " start one cycle"}, 32'(mul_start), 32'(0));
    n = 1;
    while (rsp_valid == 4'b0000 && n < 30) begin
      @(negedge blif_clk_net);
      n++;
    end
    check({tag, " start-to-rsp latency"}, 32'(n), 32'(lat));
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(oh));
    check({tag, " rsp_p"}, 32'(rsp_p), 32'(p));
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(err));
    if (hold > 0) begin
      stable_ok = 1'b1;
      no_start  = 1'b1;
      no_grant  = 1'b1;
      rsp_ready = ~oh;
      for (int i = 0; i < hold; i++) begin
        @(negedge blif_clk_net);
        if (rsp_valid !== oh || rsp_p !== p || rsp_err !== err) stable_ok = 1'b0;
        if (mul_start !== 1'b0) no_start = 1'b0;
        if (req_ready !== 4'b0000) no_grant = 1'b0;
      end
      check({tag, " hold stable"}, 32'(stable_ok), 32'(1));
      check({tag, " hold no start"}, 32'(no_start), 32'(1));
      check({tag, " hold no grant"}, 32'(no_grant), 32'(1));
    end
    rsp_ready = oh;
    @(negedge blif_clk_net);
    rsp_ready = 4'b0000;
    check({tag, " cleared after handshake"}, 32'({rsp_valid, rsp_p, rsp_err, busy}), 32'(0));
  endtask

  initial begin
    int n;
    blif_reset_net = 1'b1;
    req_valid      = 4'b0000;
    req_a          = 16'h0000;
    req_b          = 16'h0000;
    rsp_ready      = 4'b0000;
    do_reset("reset");

    // Single requester, largest operands.
    set_req(0, 4'hF, 4'hF);
    req_valid = 4'b0001;
    run_op(0, 4'hF, 4'hF, 8'hE1, 1'b0, 7, 1'b0, 0, "t1");

    // All requesters held from reset release: order 0,1,2,3,0.
    set_req(0, 4'h3, 4'h5);
    set_req(1, 4'h9, 4'h7);
    set_req(2, 4'h0, 4'hC);
    set_req(3, 4'hA, 4'h6);
    req_valid = 4'b1111;
    do_reset("t2 reset");
    run_op(0, 4'h3, 4'h5, 8'h0F, 1'b0, 7, 1'b1, 0, "t2 r0");
    run_op(1, 4'h9, 4'h7, 8'h3F, 1'b0, 7, 1'b1, 0, "t2 r1");
    run_op(2, 4'h0, 4'hC, 8'h00, 1'b0, 7, 1'b1, 0, "t2 r2");
    run_op(3, 4'hA, 4'h6, 8'h3C, 1'b0, 7, 1'b1, 0, "t2 r3");
    run_op(0, 4'h3, 4'h5, 8'h0F, 1'b0, 7, 1'b1, 0, "t2 r0 again");
    req_valid = 4'b0000;

    // READY stuck high: accepted only at the third WAIT cycle.
    mode = 1;
    set_req(1, 4'h7, 4'hB);
    req_valid = 4'b0010;
    run_op(1, 4'h7, 4'hB, 8'h4D, 1'b0, 4, 1'b0, 0, "t3");
    mode = 0;

    // READY never comes: error response after 15 WAIT cycles.
    mode = 2;
    set_req(2, 4'h5, 4'h5);
    req_valid = 4'b0100;
    run_op(2, 4'h5, 4'h5, 8'h00, 1'b1, 16, 1'b0, 0, "t4");
    mode = 0;

    // Pointer moved past requester 2 after the error response.
    set_req(2, 4'h2, 4'h3);
    set_req(3, 4'hD, 4'hD);
    req_valid = 4'b1100;
    run_op(3, 4'hD, 4'hD, 8'hA9, 1'b0, 7, 1'b0, 0, "t4 ptr");
    req_valid = 4'b0000;

    // Response withheld with requester 1 pending.
    set_req(0, 4'hC, 4'hB);
    set_req(1, 4'h4, 4'h4);
    req_valid = 4'b0011;
    run_op(0, 4'hC, 4'hB, 8'h84, 1'b0, 7, 1'b0, 10, "t5 r0");
    run_op(1, 4'h4, 4'h4, 8'h10, 1'b0, 7, 1'b0, 0, "t5 r1");

    // Reset during WAIT, then arbitration restarts from pointer 0.
    set_req(0, 4'h3, 4'h3);
    req_valid = 4'b0001;
    #1;
    n = 0;
    while (req_ready == 4'b0000 && n < 20) begin
      @(negedge blif_clk_net);
      n++;
    end
    check("t6 grant", 32'(req_ready), 32'(4'b0001));
    @(negedge blif_clk_net);
    req_valid = 4'b0000;
    @(negedge blif_clk_net);
    check("t6 start", 32'(mul_start), 32'(1));
    repeat (3) @(negedge blif_clk_net);
    check("t6 busy in wait", 32'(busy), 32'(1));
    blif_reset_net = 1'b1;
    @(negedge blif_clk_net);
    check("t6 outputs zero after reset",
          32'({req_ready, rsp_valid, rsp_p, rsp_err, mul_start, mul_a, mul_b, busy}), 32'(0));
    blif_reset_net = 1'b0;
    set_req(1, 4'h6, 4'h7);
    set_req(3, 4'h1, 4'h1);
    req_valid = 4'b1010;
    run_op(1, 4'h6, 4'h7, 8'h2A, 1'b0, 7, 1'b0, 0, "t6 post");
    req_valid = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
